// File: rtl/servo_pkg.sv
// Shared servo timing constants and decoder state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package servo_pkg;

  localparam int CLK_HZ             = 50_000_000;
  localparam int CLKS_PER_DEG       = 515;       // 10.3 us per degree
  localparam int MIN_PULSE_CLKS     = 27_250;    // 545 us at 0 degrees
  localparam int MAX_PULSE_CLKS     = 125_000;   // 2.5 ms, longer is illegal
  localparam int MAX_ANGLE          = 180;
  localparam int FRAME_TIMEOUT_CLKS = 1_250_000; // 25 ms rise-to-rise

  localparam int WIDTH_W = 18;
  localparam int FRAME_W = 21;
  localparam int PHASE_W = 10;
  localparam int ANGLE_W = 8;

  typedef enum logic [2:0] {
    WAIT_LOW,
    WAIT_RISE,
    MEASURE,
    DONE,
    STUCK_HIGH
  } dec_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the PWM input with rise/fall strobes.
// Latency: sync follows pwm_in after 2 clk edges; rise/fall are combinational on sync.
// Backpressure: none, free-running.
module pwm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  // Resetting the chain to 1 means a line already high at reset release
  // never produces a rise, so a partial pulse cannot start a measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pwm_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pwm_angle_decoder.sv
// Measures servo pulse high time and converts it to an angle 0..MAX_ANGLE.
// Latency: angle/strobe update 4 clk edges after pwm_in is first sampled low.
// Backpressure: none; one result per pulse, strobed for a single cycle.
module pwm_angle_decoder #(
  parameter int CLKS_PER_DEG       = servo_pkg::CLKS_PER_DEG,
  parameter int MIN_PULSE_CLKS     = servo_pkg::MIN_PULSE_CLKS,
  parameter int MAX_PULSE_CLKS     = servo_pkg::MAX_PULSE_CLKS,
  parameter int MAX_ANGLE          = servo_pkg::MAX_ANGLE,
  parameter int FRAME_TIMEOUT_CLKS = servo_pkg::FRAME_TIMEOUT_CLKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] angle,
  output logic       angle_strobe,
  output logic       angle_valid,
  output logic       pulse_err,
  output logic       signal_lost
);

  import servo_pkg::*;

  // Degree counting starts half a degree early so the floor division rounds.
  localparam logic [WIDTH_W-1:0] START_W   = WIDTH_W'(MIN_PULSE_CLKS - CLKS_PER_DEG / 2);
  localparam logic [WIDTH_W-1:0] MAX_W_M1  = WIDTH_W'(MAX_PULSE_CLKS - 1);
  localparam logic [PHASE_W-1:0] PH_LAST   = PHASE_W'(CLKS_PER_DEG - 1);
  localparam logic [ANGLE_W-1:0] DEG_MAX   = ANGLE_W'(MAX_ANGLE);
  localparam logic [FRAME_W-1:0] FRAME_LIM = FRAME_W'(FRAME_TIMEOUT_CLKS);

  logic sync, rise, fall;

  dec_state_t state_q, state_d;
  logic [WIDTH_W-1:0] width_q;
  logic [PHASE_W-1:0] phase_q;
  logic [ANGLE_W-1:0] deg_q;
  logic [FRAME_W-1:0] frame_q;

  logic done_ok, done_bad, overflow, timeout;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .sync   (sync),
    .rise   (rise),
    .fall   (fall)
  );

  assign timeout = (frame_q == FRAME_LIM);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_LOW;
    else        state_q <= state_d;
  end

  // Next-state decode and per-pulse result flags.
  always_comb begin
    state_d  = state_q;
    done_ok  = 1'b0;
    done_bad = 1'b0;
    overflow = 1'b0;
    case (state_q)
      WAIT_LOW:   if (!sync) state_d = WAIT_RISE;
      WAIT_RISE:  if (rise) state_d = MEASURE;
      MEASURE: begin
        if (fall) begin
          state_d = DONE;
        end else if (width_q >= MAX_W_M1) begin
          // This cycle is high sample MAX_PULSE_CLKS+1: the pulse is too long.
          overflow = 1'b1;
          state_d  = STUCK_HIGH;
        end
      end
      DONE: begin
        state_d = WAIT_RISE;
        if (width_q >= START_W) done_ok  = 1'b1;
        else                    done_bad = 1'b1;
      end
      STUCK_HIGH: if (!sync) state_d = WAIT_RISE;
      default:    state_d = WAIT_LOW;
    endcase
  end

  // Width/phase/degree counters; the fall cycle is counted so width ends at W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q <= '0;
      phase_q <= '0;
      deg_q   <= '0;
    end else if (state_q == WAIT_RISE && rise) begin
      width_q <= '0;
      phase_q <= '0;
      deg_q   <= '0;
    end else if (state_q == MEASURE) begin
      width_q <= width_q + WIDTH_W'(1);
      if (width_q >= START_W) begin
        if (phase_q == PH_LAST) begin
          phase_q <= '0;
          if (deg_q != DEG_MAX) deg_q <= deg_q + ANGLE_W'(1);
        end else begin
          phase_q <= phase_q + PHASE_W'(1);
        end
      end
    end
  end

  // Frame watchdog: rise-to-rise counter, saturating at the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        frame_q <= '0;
    else if (rise)     frame_q <= '0;
    else if (!timeout) frame_q <= frame_q + FRAME_W'(1);
  end

  // Result registers; a good pulse wins over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle        <= '0;
      angle_strobe <= 1'b0;
      angle_valid  <= 1'b0;
      pulse_err    <= 1'b0;
      signal_lost  <= 1'b0;
    end else begin
      angle_strobe <= done_ok;
      pulse_err    <= done_bad | overflow;
      if (done_ok) begin
        angle       <= deg_q;
        angle_valid <= 1'b1;
        signal_lost <= 1'b0;
      end else if (timeout) begin
        angle_valid <= 1'b0;
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_angle_decoder.sv
// Directed bench for pwm_angle_decoder using a time-scaled timing law.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_angle_decoder;

  // Scaled law: 4 clks/deg, 0 deg at 40 clks, max legal 800, timeout 2000.
  localparam int CPD     = 4;
  localparam int MINW    = 40;
  localparam int MAXW    = 800;
  localparam int TMO     = 2000;
  localparam int FRAME   = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] angle;
  logic       angle_strobe;
  logic       angle_valid;
  logic       pulse_err;
  logic       signal_lost;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  pwm_angle_decoder #(
    .CLKS_PER_DEG       (CPD),
    .MIN_PULSE_CLKS     (MINW),
    .MAX_PULSE_CLKS     (MAXW),
    .MAX_ANGLE          (180),
    .FRAME_TIMEOUT_CLKS (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_in       (pwm_in),
    .angle        (angle),
    .angle_strobe (angle_strobe),
    .angle_valid  (angle_valid),
    .pulse_err    (pulse_err),
    .signal_lost  (signal_lost)
  );

  // Event counters sampled away from the active edge.
  always @(negedge clk) begin
    if (angle_strobe) strobe_cnt++;
    if (pulse_err)    err_cnt++;
  end

  typedef struct {
    int         w;
    int         exp_strobes;
    int         exp_errs;
    logic [7:0] exp_angle;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int w, input int lo);
    pwm_in = 1'b1;
    cyc(w);
    pwm_in = 1'b0;
    cyc(lo);
  endtask

  initial begin
    int s0, e0, lat;
    int la[5];

    // width, strobes, errors, angle afterwards
    vecs[0] = '{40,  1, 0, 8'd0};    // 0 deg nominal
    vecs[1] = '{400, 1, 0, 8'd90};   // 90 deg nominal
    vecs[2] = '{760, 1, 0, 8'd180};  // 180 deg nominal
    vecs[3] = '{41,  1, 0, 8'd0};    // just below rounding step
    vecs[4] = '{42,  1, 0, 8'd1};    // first width rounding to 1 deg
    vecs[5] = '{37,  0, 1, 8'd1};    // too short: error, angle held
    vecs[6] = '{38,  1, 0, 8'd0};    // shortest legal width
    vecs[7] = '{800, 1, 0, 8'd180};  // longest legal, saturated
    vecs[8] = '{220, 1, 0, 8'd45};
    la = '{0, 90, 180, 37, 123};

    cyc(3);
    check("reset_angle", int'(angle), 0);
    check("reset_strobe", int'(angle_strobe), 0);
    check("reset_valid", int'(angle_valid), 0);
    check("reset_err", int'(pulse_err), 0);
    check("reset_lost", int'(signal_lost), 0);
    rst_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 9; i++) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      pulse(vecs[i].w, FRAME - vecs[i].w);
      check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, vecs[i].exp_strobes);
      check($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
      check($sformatf("vec%0d_angle", i), int'(angle), int'(vecs[i].exp_angle));
      check($sformatf("vec%0d_valid", i), int'(angle_valid), 1);
    end

    // Result latency measured from the first edge sampling the line low.
    pwm_in = 1'b1;
    cyc(400);
    pwm_in = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (angle_strobe) begin
        lat = k;
        break;
      end
    end
    check("latency_edges", lat, 4);
    check("latency_angle", int'(angle), 90);
    @(posedge clk);
    #1;
    cyc(500);

    // Line held high past the legal maximum.
    s0 = strobe_cnt;
    e0 = err_cnt;
    pulse(1200, 600);
    check("stuck_errs", err_cnt - e0, 1);
    check("stuck_strobes", strobe_cnt - s0, 0);
    check("stuck_angle", int'(angle), 90);
    s0 = strobe_cnt;
    pulse(400, 600);
    check("after_stuck_angle", int'(angle), 90);
    check("after_stuck_strobes", strobe_cnt - s0, 1);

    // Generator model: width = MINW + a*CPD must decode back to a.
    for (int i = 0; i < 5; i++) begin
      s0 = strobe_cnt;
      pulse(MINW + la[i] * CPD, FRAME - (MINW + la[i] * CPD));
      check($sformatf("loop%0d_angle", i), int'(angle), la[i]);
      check($sformatf("loop%0d_strobes", i), strobe_cnt - s0, 1);
    end

    // Signal loss after a good pulse, recovery on the next one.
    pulse(400, 1590);
    check("pre_loss_lost", int'(signal_lost), 0);
    check("pre_loss_valid", int'(angle_valid), 1);
    cyc(30);
    check("loss_lost", int'(signal_lost), 1);
    check("loss_valid", int'(angle_valid), 0);
    check("loss_angle", int'(angle), 90);
    pulse(760, 240);
    check("recover_lost", int'(signal_lost), 0);
    check("recover_valid", int'(angle_valid), 1);
    check("recover_angle", int'(angle), 180);

    // Reset in the middle of a pulse; the remainder must be discarded.
    pwm_in = 1'b1;
    cyc(200);
    rst_n = 1'b0;
    cyc(2);
    check("midrst_angle", int'(angle), 0);
    check("midrst_valid", int'(angle_valid), 0);
    check("midrst_lost", int'(signal_lost), 0);
    rst_n = 1'b1;
    s0 = strobe_cnt;
    e0 = err_cnt;
    cyc(200);
    pwm_in = 1'b0;
    cyc(300);
    check("partial_strobes", strobe_cnt - s0, 0);
    check("partial_errs", err_cnt - e0, 0);
    check("partial_valid", int'(angle_valid), 0);
    s0 = strobe_cnt;
    pulse(400, 600);
    check("post_rst_angle", int'(angle), 90);
    check("post_rst_strobes", strobe_cnt - s0, 1);
    check("post_rst_valid", int'(angle_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
